// File: rtl/fft_bank_xbar_pkg.sv
// Shared sizing constants and the lane request record for the FFT bank crossbar.
package fft_bank_xbar_pkg;
  localparam int LANES      = 8;
  localparam int BANK_WIDTH = 3;
  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 16;

  typedef struct packed {
    logic [BANK_WIDTH-1:0] bank;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } lane_req_t;
endpackage

// File: rtl/fft_bank_xbar_if.sv
// Request, bank-port and result bundle between the address generator, memories and datapath.
interface fft_bank_xbar_if;
  import fft_bank_xbar_pkg::*;

  logic                                   in_valid;
  logic                                   in_we;
  logic                                   in_last;
  logic [LANES-1:0]                       lane_mask;
  logic [LANES-1:0][BANK_WIDTH-1:0]       in_bank;
  logic [LANES-1:0][ADDR_WIDTH-1:0]       in_addr;
  logic [LANES-1:0][DATA_WIDTH-1:0]       in_wdata;
  logic [LANES-1:0]                       mem_en;
  logic [LANES-1:0]                       mem_we;
  logic [LANES-1:0][ADDR_WIDTH-1:0]       mem_addr;
  logic [LANES-1:0][DATA_WIDTH-1:0]       mem_wdata;
  logic [LANES-1:0][DATA_WIDTH-1:0]       mem_rdata;
  logic                                   out_valid;
  logic                                   out_last;
  logic [LANES-1:0][DATA_WIDTH-1:0]       out_data;
  logic [LANES-1:0]                       out_mask;
  logic                                   conflict_err;
  logic [CNT_WIDTH-1:0]                   conflict_beat;

  modport slave (
    input  in_valid, in_we, in_last, lane_mask, in_bank, in_addr, in_wdata, mem_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, out_valid, out_last, out_data, out_mask,
           conflict_err, conflict_beat
  );

  modport master (
    output in_valid, in_we, in_last, lane_mask, in_bank, in_addr, in_wdata, mem_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, out_valid, out_last, out_data, out_mask,
           conflict_err, conflict_beat
  );
endinterface

// File: rtl/fft_bank_arb.sv
// Per-bank lowest-index priority encoder over the lane match vector.
module fft_bank_arb #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] match_i,
  output logic [W-1:0] idx_o,
  output logic         found_o,
  output logic         multi_o
);
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (match_i[i]) begin
        idx_o   = W'(i);
        found_o = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more lanes hit.
  assign multi_o = |(match_i & (match_i - N'(1)));
endmodule

// File: rtl/fft_bank_xbar.sv
// Lane->bank crossbar with conflict check, and bank->lane read-data return path.
module fft_bank_xbar
  import fft_bank_xbar_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  fft_bank_xbar_if.slave bus
);
  // [0]=S0 beat, [1]=S2 read beat, [2]=S3 result
  logic [2:0]                       vld_pipe_q;
  logic                             s0_we_q, s0_last_q;
  logic [LANES-1:0]                 s0_mask_q;
  lane_req_t [LANES-1:0]            s0_req_q;

  logic [LANES-1:0][LANES-1:0]      match;
  logic [LANES-1:0][BANK_WIDTH-1:0] win_idx;
  logic [LANES-1:0]                 found, multi, lane_win;
  logic [LANES-1:0]                 mem_en, mem_we;
  logic [LANES-1:0][ADDR_WIDTH-1:0] mem_addr;
  logic [LANES-1:0][DATA_WIDTH-1:0] mem_wdata;
  logic                             conflict;

  logic                             s2_last_q;
  logic [LANES-1:0]                 s2_mask_q, s2_win_q;
  logic [LANES-1:0][BANK_WIDTH-1:0] s2_bank_q;

  logic                             out_last_q;
  logic [LANES-1:0]                 out_mask_q;
  logic [LANES-1:0][DATA_WIDTH-1:0] out_data_q;
  logic [CNT_WIDTH-1:0]             beat_cnt_q, conflict_beat_q;
  logic                             conflict_err_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      vld_pipe_q[0] <= 1'b0;
      s0_we_q       <= 1'b0;
      s0_last_q     <= 1'b0;
      s0_mask_q     <= '0;
      s0_req_q      <= '0;
    end else begin
      vld_pipe_q[0] <= bus.in_valid;
      if (bus.in_valid) begin
        s0_we_q   <= bus.in_we;
        s0_last_q <= bus.in_last;
        s0_mask_q <= bus.lane_mask;
        for (int l = 0; l < LANES; l++) begin
          s0_req_q[l].bank  <= bus.in_bank[l];
          s0_req_q[l].addr  <= bus.in_addr[l];
          s0_req_q[l].wdata <= bus.in_wdata[l];
        end
      end
    end
  end

  always_comb begin
    match = '0;
    for (int b = 0; b < LANES; b++)
      for (int l = 0; l < LANES; l++)
        match[b][l] = s0_mask_q[l] && (s0_req_q[l].bank == BANK_WIDTH'(b));
  end

  for (genvar b = 0; b < LANES; b++) begin : g_arb
    fft_bank_arb #(.N(LANES), .W(BANK_WIDTH)) u_arb (
      .match_i (match[b]),
      .idx_o   (win_idx[b]),
      .found_o (found[b]),
      .multi_o (multi[b])
    );
  end

  always_comb begin
    mem_en    = '0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    lane_win  = '0;
    for (int b = 0; b < LANES; b++) begin
      if (vld_pipe_q[0] && found[b]) begin
        mem_en[b]    = 1'b1;
        mem_we[b]    = s0_we_q;
        mem_addr[b]  = s0_req_q[win_idx[b]].addr;
        mem_wdata[b] = s0_req_q[win_idx[b]].wdata;
      end
    end
    // A lane keeps its data only if its bank's encoder picked it.
    for (int l = 0; l < LANES; l++)
      lane_win[l] = s0_mask_q[l] && found[s0_req_q[l].bank] &&
                    (win_idx[s0_req_q[l].bank] == BANK_WIDTH'(l));
  end

  assign conflict = vld_pipe_q[0] && (|multi);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      beat_cnt_q      <= '0;
      conflict_err_q  <= 1'b0;
      conflict_beat_q <= '0;
    end else begin
      if (vld_pipe_q[0])
        beat_cnt_q <= s0_last_q ? '0 : beat_cnt_q + CNT_WIDTH'(1);
      if (conflict && !conflict_err_q) begin
        conflict_err_q  <= 1'b1;
        conflict_beat_q <= beat_cnt_q;
      end
    end
  end

  // S2 rides alongside the single-cycle bank read; S3 un-routes the returned words.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      vld_pipe_q[2:1] <= '0;
      s2_last_q       <= 1'b0;
      s2_mask_q       <= '0;
      s2_win_q        <= '0;
      s2_bank_q       <= '0;
      out_last_q      <= 1'b0;
      out_mask_q      <= '0;
      out_data_q      <= '0;
    end else begin
      vld_pipe_q[1] <= vld_pipe_q[0] && !s0_we_q;
      s2_last_q     <= s0_last_q;
      s2_mask_q     <= s0_mask_q;
      s2_win_q      <= lane_win;
      for (int l = 0; l < LANES; l++)
        s2_bank_q[l] <= s0_req_q[l].bank;
      vld_pipe_q[2] <= vld_pipe_q[1];
      out_last_q    <= vld_pipe_q[1] && s2_last_q;
      if (vld_pipe_q[1]) begin
        out_mask_q <= s2_mask_q;
        for (int l = 0; l < LANES; l++)
          out_data_q[l] <= s2_win_q[l] ? bus.mem_rdata[s2_bank_q[l]] : '0;
      end
    end
  end

  assign bus.mem_en        = mem_en;
  assign bus.mem_we        = mem_we;
  assign bus.mem_addr      = mem_addr;
  assign bus.mem_wdata     = mem_wdata;
  assign bus.out_valid     = vld_pipe_q[2];
  assign bus.out_last      = out_last_q;
  assign bus.out_mask      = out_mask_q;
  assign bus.out_data      = out_data_q;
  assign bus.conflict_err  = conflict_err_q;
  assign bus.conflict_beat = conflict_beat_q;
endmodule

// File: tb/tb_fft_bank_xbar.sv
// Directed bench for fft_bank_xbar with a small per-bank memory model.
module tb_fft_bank_xbar;
  import fft_bank_xbar_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_bank_xbar_if bus();
  fft_bank_xbar dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Bank memories: unwritten words read as 0x100+bank.
  logic [DATA_WIDTH-1:0]            mem_m [LANES][256];
  bit                               wr_m  [LANES][256];
  logic [LANES-1:0][DATA_WIDTH-1:0] rdata_q = '0;
  assign bus.mem_rdata = rdata_q;

  always @(posedge clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (bus.mem_en[b]) begin
        if (bus.mem_we[b]) begin
          mem_m[b][bus.mem_addr[b][7:0]] <= bus.mem_wdata[b];
          wr_m[b][bus.mem_addr[b][7:0]]  <= 1'b1;
        end else begin
          rdata_q[b] <= wr_m[b][bus.mem_addr[b][7:0]] ? mem_m[b][bus.mem_addr[b][7:0]]
                                                      : DATA_WIDTH'(32'h100 + b);
        end
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [LANES-1:0][BANK_WIDTH-1:0] bk;
  logic [LANES-1:0][ADDR_WIDTH-1:0] ad;
  logic [LANES-1:0][DATA_WIDTH-1:0] wd;
  logic [LANES-1:0][ADDR_WIDTH-1:0] exp_addr;
  logic [LANES-1:0][DATA_WIDTH-1:0] exp_data;

  task automatic drive(input logic we, input logic last, input logic [LANES-1:0] mask);
    bus.in_valid  = 1'b1;
    bus.in_we     = we;
    bus.in_last   = last;
    bus.lane_mask = mask;
    bus.in_bank   = bk;
    bus.in_addr   = ad;
    bus.in_wdata  = wd;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_we    = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic ident_map(input int base);
    for (int l = 0; l < LANES; l++) begin
      bk[l] = BANK_WIDTH'(l);
      ad[l] = ADDR_WIDTH'(base + l);
      wd[l] = '0;
    end
  endtask

  int max_bits, n_ov, last_pos, n_last, bits;

  initial begin
    rst_n = 1'b1;
    idle();
    bus.lane_mask = '0;
    bus.in_bank = '0;
    bus.in_addr = '0;
    bus.in_wdata = '0;
    tick(); tick();
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_conflict", {bus.conflict_err, bus.conflict_beat}, 0);
    rst_n = 1'b0;
    tick();

    // beat 0: identity read
    ident_map(10);
    drive(1'b0, 1'b0, 8'hFF);
    tick(); idle();
    for (int b = 0; b < LANES; b++) exp_addr[b] = ADDR_WIDTH'(10 + b);
    check("id_mem_en", bus.mem_en, 8'hFF);
    check("id_mem_we", bus.mem_we, 0);
    check("id_mem_addr", bus.mem_addr, exp_addr);
    tick(); tick();
    for (int l = 0; l < LANES; l++) exp_data[l] = DATA_WIDTH'(32'h100 + l);
    check("id_out_valid", bus.out_valid, 1);
    check("id_out_data", bus.out_data, exp_data);
    check("id_out_mask", bus.out_mask, 8'hFF);

    // beat 1: reversed read
    for (int l = 0; l < LANES; l++) begin
      bk[l] = BANK_WIDTH'(7 - l);
      ad[l] = ADDR_WIDTH'(40 + l);
    end
    drive(1'b0, 1'b0, 8'hFF);
    tick(); idle();
    for (int b = 0; b < LANES; b++) exp_addr[b] = ADDR_WIDTH'(40 + 7 - b);
    check("rev_mem_addr", bus.mem_addr, exp_addr);
    tick(); tick();
    for (int l = 0; l < LANES; l++) exp_data[l] = DATA_WIDTH'(32'h100 + 7 - l);
    check("rev_out_data", bus.out_data, exp_data);
    check("rev_no_conflict", bus.conflict_err, 0);

    // beat 2: read with an empty mask
    ident_map(10);
    drive(1'b0, 1'b0, 8'h00);
    tick(); idle();
    check("m0_mem_en", bus.mem_en, 0);
    tick(); tick();
    check("m0_out_valid", bus.out_valid, 1);
    check("m0_out_data", bus.out_data, 0);

    // beat 3: lanes 2 and 5 collide on bank 3; lane 3 moved to bank 2
    ident_map(10);
    bk[2] = 3'd3; bk[3] = 3'd2; bk[5] = 3'd3;
    drive(1'b0, 1'b0, 8'hFF);
    tick(); idle();
    check("cf_mem_en", bus.mem_en, 8'hDF);
    check("cf_mem_addr3", bus.mem_addr[3], 12);
    tick();
    check("cf_err", bus.conflict_err, 1);
    check("cf_beat", bus.conflict_beat, 3);
    tick();
    for (int l = 0; l < LANES; l++) exp_data[l] = DATA_WIDTH'(32'h100 + l);
    exp_data[2] = 32'h103; exp_data[3] = 32'h102; exp_data[5] = '0;
    check("cf_out_data", bus.out_data, exp_data);

    // write then read, back to back
    for (int l = 0; l < LANES; l++) begin
      bk[l] = BANK_WIDTH'(l);
      ad[l] = 7;
      wd[l] = 32'hA5A50000 + l;
    end
    drive(1'b1, 1'b0, 8'hFF);
    tick();
    check("wr_mem_we", bus.mem_we, 8'hFF);
    check("wr_mem_wdata", bus.mem_wdata, wd);
    drive(1'b0, 1'b0, 8'hFF);
    tick(); idle();
    check("rd_mem_en_we", {bus.mem_en, bus.mem_we}, 16'hFF00);
    tick();
    check("wr_no_out_valid", bus.out_valid, 0);
    tick();
    check("rd_out_valid", bus.out_valid, 1);
    check("rd_out_data", bus.out_data, wd);
    check("cf_sticky", bus.conflict_err, 1);

    // point-5 stage: 10 beats, mask 0x1F, last on the 10th
    max_bits = 0; n_ov = 0; last_pos = 0; n_last = 0;
    ident_map(20);
    wd = '0;
    for (int i = 0; i < 14; i++) begin
      if (i < 10) drive(1'b0, i == 9, 8'h1F);
      else idle();
      tick();
      bits = $countones(bus.mem_en);
      if (bits > max_bits) max_bits = bits;
      if (bus.out_valid) n_ov++;
      if (bus.out_last) begin
        n_last++;
        last_pos = n_ov;
      end
    end
    check("p5_max_en_bits", max_bits, 5);
    check("p5_out_valid_cnt", n_ov, 10);
    check("p5_last_pos", last_pos, 10);
    check("p5_last_cnt", n_last, 1);
    check("p5_out_mask", bus.out_mask, 8'h1F);

    // three reads in flight, then a one-cycle reset
    ident_map(10);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'hFF);
      tick();
    end
    idle();
    rst_n = 1'b1;
    tick();
    check("mr_out_valid", bus.out_valid, 0);
    check("mr_mem_en", bus.mem_en, 0);
    check("mr_conflict", {bus.conflict_err, bus.conflict_beat}, 0);
    rst_n = 1'b0;
    tick();
    check("mr_flushed", bus.out_valid, 0);
    tick();
    check("mr_flushed2", bus.out_valid, 0);
    // first beat after reset conflicts: counter must be back at 0
    bk[2] = 3'd3; bk[3] = 3'd2; bk[5] = 3'd3;
    drive(1'b0, 1'b0, 8'hFF);
    tick(); idle();
    tick();
    check("mr_cf_err", bus.conflict_err, 1);
    check("mr_cf_beat", bus.conflict_beat, 0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
